// File: rtl/sensor_cond_pkg.sv
// Shared types and constants for the country-road sensor conditioner.
package sensor_cond_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StQual,
    StActive,
    StHold,
    StFault
  } cond_state_e;

  localparam int unsigned CarCountWidth = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reset value selectable.
module sync_2ff #(
  parameter logic ResetValue = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetValue;
      sync_q <= ResetValue;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sensor_conditioner.sv
// Synchronizes, debounces and hold-extends the raw car sensor; masks a stuck-high sensor as fault.
// Optional car counter enabled by defining SENSOR_COND_CAR_COUNT_EN.
module sensor_conditioner
  import sensor_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES     = 8,
  parameter int unsigned STUCK_CYCLES    = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_sensor,
  output logic sensor,
  output logic sensor_rise,
  output logic fault
`ifdef SENSOR_COND_CAR_COUNT_EN
  ,
  input  logic                     count_clr,
  output logic [CarCountWidth-1:0] car_count
`endif
);

  localparam int unsigned QW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned SW = $clog2(STUCK_CYCLES + 1);

  localparam logic [QW-1:0] QualLast  = QW'(DEBOUNCE_CYCLES);
  localparam logic [QW-1:0] FaultLast = QW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HoldLast  = HW'(HOLD_CYCLES);
  localparam logic [SW-1:0] StuckLast = SW'(STUCK_CYCLES - 1);

  cond_state_e   state_q;
  logic [QW-1:0] qcnt_q;
  logic [QW-1:0] fcnt_q;
  logic [HW-1:0] hcnt_q;
  logic [SW-1:0] scnt_q;
  logic          raw_sync;

  sync_2ff #(
    .ResetValue(1'b0)
  ) u_sync (
    .clk_i (clk),
    .rst_ni(rst_n),
    .d_i   (raw_sensor),
    .q_o   (raw_sync)
  );

  // Counters only ever advance while below their compare limit, so they saturate by construction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      qcnt_q      <= '0;
      fcnt_q      <= '0;
      hcnt_q      <= '0;
      scnt_q      <= '0;
      sensor      <= 1'b0;
      sensor_rise <= 1'b0;
      fault       <= 1'b0;
    end else begin
      sensor_rise <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (raw_sync) begin
            state_q <= StQual;
            qcnt_q  <= QW'(1);
          end
        end
        StQual: begin
          if (!raw_sync) begin
            state_q <= StIdle;
            qcnt_q  <= '0;
          end else if (qcnt_q == QualLast) begin
            state_q     <= StActive;
            qcnt_q      <= '0;
            scnt_q      <= '0;
            sensor      <= 1'b1;
            sensor_rise <= 1'b1;
          end else begin
            qcnt_q <= qcnt_q + QW'(1);
          end
        end
        StActive, StHold: begin
          // Stuck detection outranks every other transition; HOLD re-entry never clears scnt.
          if (scnt_q == StuckLast) begin
            state_q <= StFault;
            scnt_q  <= '0;
            hcnt_q  <= '0;
            fcnt_q  <= '0;
            sensor  <= 1'b0;
            fault   <= 1'b1;
          end else begin
            scnt_q <= scnt_q + SW'(1);
            if (state_q == StActive) begin
              if (!raw_sync) begin
                state_q <= StHold;
                hcnt_q  <= HW'(1);
              end
            end else if (raw_sync) begin
              state_q <= StActive;
              hcnt_q  <= '0;
            end else if (hcnt_q == HoldLast) begin
              state_q <= StIdle;
              hcnt_q  <= '0;
              scnt_q  <= '0;
              sensor  <= 1'b0;
            end else begin
              hcnt_q <= hcnt_q + HW'(1);
            end
          end
        end
        StFault: begin
          // Release on the DEBOUNCE_CYCLES-th consecutive low sample.
          if (raw_sync) begin
            fcnt_q <= '0;
          end else if (fcnt_q == FaultLast) begin
            state_q <= StIdle;
            fcnt_q  <= '0;
            fault   <= 1'b0;
          end else begin
            fcnt_q <= fcnt_q + QW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          sensor  <= 1'b0;
          fault   <= 1'b0;
        end
      endcase
    end
  end

`ifdef SENSOR_COND_CAR_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      car_count <= '0;
    end else if (count_clr) begin
      car_count <= '0;
    end else if (sensor_rise && (car_count != '1)) begin
      car_count <= car_count + CarCountWidth'(1);
    end
  end
`endif

endmodule
